// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu_uop_sequencer
//   Micro-sequencer between memory fetch and the dzcpu datapath. Latches the
//   opcode byte from the memory bus, looks up its flow start in the ucode LUT,
//   then walks uPC through the ucode ROM issuing micro-ops until an eof flow.
//   CB-prefixed opcodes jump through the CB LUT via the jcb micro-op.
//
// Ports
//   iClock, iReset        clock (posedge) / asynchronous active-high reset
//   iMemData, iMemReady   opcode or CB sub-opcode byte at MEM[pc] and its valid
//   iStall                datapath stall, freezes EXEC
//   iZeroFlag             Z flag for the conditional eof flows
//   oLutMop / iLutIdx     opcode to the ucode LUT / flow start index back
//   oCbLutMop / iCbLutIdx sub-opcode to the CB LUT / flow index back
//   oRomAddr / iUop       uPC to the ucode ROM / {flow, op, operand} back
//   oExecValid, oExecOp, oExecOperand   micro-op issue to the datapath
//   oPcInc, oFlagUpdate, oEof           per-uop strobes
//   oInsnCnt              retired instruction count (wraps)
//   oError                sticky abort (watchdog or CB LUT miss)
//
// state  | meaning
// IDLE   | one cycle after reset
// FETCH  | waiting for the opcode byte
// EXEC   | walking the ROM flow, one uop per unstalled cycle

module dzcpu_uop_sequencer #(
    parameter int MAX_UOPS = 32,
    parameter int CNT_W    = 16
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic [7:0]       iMemData,
    input  logic             iMemReady,
    input  logic             iStall,
    input  logic             iZeroFlag,
    output logic [7:0]       oLutMop,
    input  logic [7:0]       iLutIdx,
    output logic [7:0]       oCbLutMop,
    input  logic [7:0]       iCbLutIdx,
    output logic [7:0]       oRomAddr,
    input  logic [12:0]      iUop,
    output logic             oExecValid,
    output logic [3:0]       oExecOp,
    output logic [4:0]       oExecOperand,
    output logic             oPcInc,
    output logic             oFlagUpdate,
    output logic             oEof,
    output logic [CNT_W-1:0] oInsnCnt,
    output logic             oError
);

    // Flow and op encodings shared with the ucode ROM image.
    localparam logic [3:0] FL_NOP        = 4'd0;
    localparam logic [3:0] FL_INC        = 4'd1;
    localparam logic [3:0] FL_EOF        = 4'd2;
    localparam logic [3:0] FL_INC_EOF    = 4'd3;
    localparam logic [3:0] FL_EOF_FU     = 4'd4;
    localparam logic [3:0] FL_INC_EOF_FU = 4'd5;
    localparam logic [3:0] FL_INC_EOF_Z  = 4'd6;
    localparam logic [3:0] FL_INC_EOF_NZ = 4'd7;
    localparam logic [3:0] OP_JCB        = 4'hF;

    localparam int UC_W = $clog2(MAX_UOPS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC} state_t;

    state_t           state_q, state_d;
    logic [7:0]       upc_q, upc_d;
    logic [7:0]       ir_q, ir_d;
    logic [UC_W-1:0]  ucnt_q, ucnt_d;
    logic [CNT_W-1:0] insn_q, insn_d;
    logic             err_q, err_d;

    logic [3:0] flow;
    logic [3:0] op;
    logic       is_jcb;
    logic       has_inc;
    logic       suppress;
    logic       ends;
    logic       is_fu;
    logic       advance;
    logic       wd_hit;

    // Flow decode; any unlisted flow code behaves like nop.
    always_comb begin
        flow     = iUop[12:9];
        op       = iUop[8:5];
        is_jcb   = (op == OP_JCB);
        has_inc  = (flow == FL_INC) || (flow == FL_INC_EOF) || (flow == FL_INC_EOF_FU) ||
                   (flow == FL_INC_EOF_Z) || (flow == FL_INC_EOF_NZ);
        // Conditional eof taken: the uop ends the instruction without issuing.
        suppress = ((flow == FL_INC_EOF_Z) && iZeroFlag) ||
                   ((flow == FL_INC_EOF_NZ) && !iZeroFlag);
        ends     = (flow == FL_EOF) || (flow == FL_INC_EOF) || (flow == FL_EOF_FU) ||
                   (flow == FL_INC_EOF_FU) || suppress;
        is_fu    = (flow == FL_EOF_FU) || (flow == FL_INC_EOF_FU);
        // jcb must see the CB sub-opcode on the bus before it can move on.
        advance  = (state_q == ST_EXEC) && !iStall && (!is_jcb || iMemReady);
        // This uop is the last one the watchdog allows.
        wd_hit   = (ucnt_q == UC_W'(MAX_UOPS - 1));
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            ir_q    <= '0;
            ucnt_q  <= '0;
            insn_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            ir_q    <= ir_d;
            ucnt_q  <= ucnt_d;
            insn_q  <= insn_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        ir_d    = ir_q;
        ucnt_d  = ucnt_q;
        insn_d  = insn_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (iMemReady) begin
                    ir_d    = iMemData;
                    upc_d   = iLutIdx;
                    ucnt_d  = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (advance) begin
                    ucnt_d = ucnt_q + UC_W'(1);
                    if (is_jcb) begin
                        if ((iCbLutIdx == 8'd0) || wd_hit) begin
                            err_d   = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            upc_d = iCbLutIdx;
                        end
                    end else if (ends) begin
                        insn_d  = insn_q + CNT_W'(1);
                        state_d = ST_FETCH;
                    end else if (wd_hit) begin
                        err_d   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        upc_d = upc_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        oExecValid   = advance && !is_jcb && !suppress;
        oPcInc       = advance && has_inc;
        oFlagUpdate  = advance && !is_jcb && ends && is_fu;
        oEof         = advance && !is_jcb && ends;
        // Op and operand are held at zero whenever nothing is being issued.
        oExecOp      = oExecValid ? iUop[8:5] : 4'd0;
        oExecOperand = oExecValid ? iUop[4:0] : 5'd0;
        oLutMop      = (state_q == ST_FETCH) ? iMemData : ir_q;
        oCbLutMop    = iMemData;
        oRomAddr     = upc_q;
        oInsnCnt     = insn_q;
        oError       = err_q;
    end

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
module tb_dzcpu_uop_sequencer;

    localparam int MAXU = 32;

    logic        clk = 1'b0;
    logic        iReset;
    logic [7:0]  iMemData;
    logic        iMemReady;
    logic        iStall;
    logic        iZeroFlag;
    logic [7:0]  oLutMop;
    logic [7:0]  iLutIdx;
    logic [7:0]  oCbLutMop;
    logic [7:0]  iCbLutIdx;
    logic [7:0]  oRomAddr;
    logic [12:0] iUop;
    logic        oExecValid;
    logic [3:0]  oExecOp;
    logic [4:0]  oExecOperand;
    logic        oPcInc;
    logic        oFlagUpdate;
    logic        oEof;
    logic [15:0] oInsnCnt;
    logic        oError;

    logic [12:0] rom   [256];
    logic [7:0]  lut   [256];
    logic [7:0]  cblut [256];

    assign iUop      = rom[oRomAddr];
    assign iLutIdx   = lut[oLutMop];
    assign iCbLutIdx = cblut[oCbLutMop];

    always #5 clk = ~clk;

    dzcpu_uop_sequencer #(.MAX_UOPS(MAXU), .CNT_W(16)) dut (
        .iClock(clk), .iReset(iReset), .iMemData(iMemData), .iMemReady(iMemReady),
        .iStall(iStall), .iZeroFlag(iZeroFlag), .oLutMop(oLutMop), .iLutIdx(iLutIdx),
        .oCbLutMop(oCbLutMop), .iCbLutIdx(iCbLutIdx), .oRomAddr(oRomAddr), .iUop(iUop),
        .oExecValid(oExecValid), .oExecOp(oExecOp), .oExecOperand(oExecOperand),
        .oPcInc(oPcInc), .oFlagUpdate(oFlagUpdate), .oEof(oEof),
        .oInsnCnt(oInsnCnt), .oError(oError)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_insn = '0;
    bit          exp_err  = 1'b0;

    typedef struct {
        logic [7:0] addr;
        bit         jcb;
        logic [3:0] strb;   // {exec_valid, pc_inc, flag_update, eof}
    } step_t;

    step_t trace[$];
    bit    trace_err;
    bit    trace_eof;

    function automatic logic [12:0] mk(input int flow, input int op, input int opnd);
        mk = {4'(flow), 4'(op), 5'(opnd)};
    endfunction

    // Expected uop walk of one instruction, straight from the flow rules.
    task automatic build_trace(input logic [7:0] start, input logic [7:0] cbidx, input bit z);
        logic [7:0] upc;
        int         n;
        bit         done;
        int         f, op;
        bit         inc, supp, ends;
        step_t      s;
        upc = start; n = 0; done = 0;
        trace.delete(); trace_err = 0; trace_eof = 0;
        while (!done) begin
            f  = int'(rom[upc][12:9]);
            op = int'(rom[upc][8:5]);
            n++;
            inc  = (f == 1) || (f == 3) || (f == 5) || (f == 6) || (f == 7);
            supp = (f == 6 && z) || (f == 7 && !z);
            ends = (f >= 2 && f <= 5) || supp;
            s.addr = upc;
            if (op == 15) begin
                s.jcb = 1; s.strb = {1'b0, inc, 2'b00};
                trace.push_back(s);
                if (cbidx == 8'd0 || n == MAXU) begin trace_err = 1; done = 1; end
                else upc = cbidx;
            end else begin
                s.jcb = 0;
                s.strb = {!supp, inc, ends && (f == 4 || f == 5), ends};
                trace.push_back(s);
                if (ends) begin trace_eof = 1; done = 1; end
                else if (n == MAXU) begin trace_err = 1; done = 1; end
                else upc = upc + 8'd1;
            end
        end
    endtask

    // Drives one instruction from FETCH back to FETCH and checks every cycle.
    task automatic run_insn(input logic [7:0] opc, input logic [7:0] cb, input bit z,
                            input int fetch_wait, input int stall_addr, input int stall_n,
                            input int hold_n, input bit rnd, input string tag);
        int nst, nhold;
        logic [3:0] act;
        build_trace(lut[opc], cblut[cb], z);
        for (int i = 0; i < fetch_wait; i++) begin
            @(negedge clk);
            iMemData = opc; iMemReady = 0; iStall = 0; iZeroFlag = z;
            #1;
            vectors++;
            act = {oExecValid, oPcInc, oFlagUpdate, oEof};
            if (act !== 4'b0 || oLutMop !== opc) begin
                miscompares++;
                $display("FAIL %s fetch_wait strobes=%b lutmop=%h need 0000/%h", tag, act, oLutMop, opc);
            end
        end
        @(negedge clk);
        iMemData = opc; iMemReady = 1; iStall = 0; iZeroFlag = z;
        #1;
        vectors++;
        if (oLutMop !== opc || oExecValid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s fetch lutmop=%h exec=%b need %h/0", tag, oLutMop, oExecValid, opc);
        end
        foreach (trace[k]) begin
            nst = (int'(trace[k].addr) == stall_addr) ? stall_n :
                  (rnd && ($urandom % 4 == 0)) ? int'($urandom_range(1, 2)) : 0;
            nhold = !trace[k].jcb ? 0 : rnd ? int'($urandom_range(0, 2)) : hold_n;
            for (int i = 0; i < nst + nhold; i++) begin
                @(negedge clk);
                iMemData = cb;
                iStall = (i < nst);
                iMemReady = (i < nst) ? 1'($urandom) : 1'b0;
                #1;
                vectors++;
                act = {oExecValid, oPcInc, oFlagUpdate, oEof};
                if (act !== 4'b0 || oRomAddr !== trace[k].addr) begin
                    miscompares++;
                    $display("FAIL %s hold strobes=%b addr=%0d need 0000/%0d", tag, act, oRomAddr, trace[k].addr);
                end
            end
            @(negedge clk);
            iMemData = cb; iStall = 0;
            iMemReady = trace[k].jcb ? 1'b1 : 1'($urandom);
            #1;
            vectors++;
            act = {oExecValid, oPcInc, oFlagUpdate, oEof};
            if (act !== trace[k].strb || oRomAddr !== trace[k].addr || oLutMop !== opc) begin
                miscompares++;
                $display("FAIL %s step%0d strobes=%b addr=%0d lutmop=%h need %b/%0d/%h",
                         tag, k, act, oRomAddr, oLutMop, trace[k].strb, trace[k].addr, opc);
            end
            if (trace[k].strb[3]) begin
                vectors++;
                if ({oExecOp, oExecOperand} !== rom[trace[k].addr][8:0]) begin
                    miscompares++;
                    $display("FAIL %s issue op/operand=%h need %h", tag, {oExecOp, oExecOperand},
                             rom[trace[k].addr][8:0]);
                end
            end
        end
        if (trace_eof) exp_insn = exp_insn + 16'd1;
        if (trace_err) exp_err = 1'b1;
        @(negedge clk);
        iMemReady = 0; iStall = 0;
        #1;
        vectors++;
        if (oInsnCnt !== exp_insn || oError !== exp_err || oExecValid !== 1'b0 || oLutMop !== iMemData) begin
            miscompares++;
            $display("FAIL %s end insn=%0d err=%b exec=%b lutmop=%h need %0d/%b/0/%h",
                     tag, oInsnCnt, oError, oExecValid, oLutMop, exp_insn, exp_err, iMemData);
        end
    endtask

    task automatic init_directed();
        for (int i = 0; i < 256; i++) begin rom[i] = '0; lut[i] = 8'd0; cblut[i] = 8'd0; end
        lut[8'h0C] = 8'd32;  rom[32] = mk(3, 2, 1);                 // INC r_c
        lut[8'h20] = 8'd17;                                         // JR NZ,n
        rom[17] = mk(1, 1, 3); rom[18] = mk(0, 4, 5); rom[19] = mk(6, 5, 6);
        rom[20] = mk(0, 6, 7); rom[21] = mk(0, 7, 8); rom[22] = mk(2, 8, 9);
        lut[8'hCB] = 8'd13;                                         // CB prefix
        rom[13] = mk(0, 1, 2); rom[14] = mk(0, 2, 3); rom[15] = mk(1, 15, 0);
        cblut[8'h7C] = 8'd16; rom[16] = mk(4, 9, 7);                // BIT 7,H
        lut[8'hCD] = 8'd54;                                         // CALL nn
        for (int i = 54; i < 59; i++) rom[i] = mk(i % 2, 3, i % 32);
        rom[59] = mk(2, 10, 4);
        lut[8'hC9] = 8'd85;                                         // RET
        for (int i = 85; i < 89; i++) rom[i] = mk(0, 11, i % 32);
        rom[89] = mk(2, 12, 1);
        lut[8'h01] = 8'd200;                                        // runaway flow
    endtask

    task automatic test_reset();
        iReset = 1; iMemData = 8'h00; iMemReady = 0; iStall = 0; iZeroFlag = 0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({oExecValid, oPcInc, oFlagUpdate, oEof, oError} !== 5'b0 || oRomAddr !== 8'd0 ||
            oInsnCnt !== 16'd0 || oLutMop !== 8'd0 || {oExecOp, oExecOperand} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_state strobes=%b err=%b addr=%0d cnt=%0d lutmop=%h need zeros",
                     {oExecValid, oPcInc, oFlagUpdate, oEof}, oError, oRomAddr, oInsnCnt, oLutMop);
        end
        @(negedge clk);
        iReset = 0; iMemData = 8'h0C; iMemReady = 1;
        #1;
        vectors++;
        if (oLutMop !== 8'd0 || oExecValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle lutmop=%h exec=%b need 00/0", oLutMop, oExecValid);
        end
        exp_insn = '0; exp_err = 0;
    endtask

    task automatic test_incr_c();
        run_insn(8'h0C, 8'h00, 1'b0, 0, -1, 0, 0, 0, "incr_c");
    endtask

    task automatic test_jrnz();
        run_insn(8'h20, 8'h00, 1'b1, 1, -1, 0, 0, 0, "jrnz_z1");
        run_insn(8'h20, 8'h00, 1'b0, 0, -1, 0, 0, 0, "jrnz_z0");
    endtask

    task automatic test_cb_bit7();
        run_insn(8'hCB, 8'h7C, 1'b0, 0, -1, 0, 0, 0, "cb_bit7");
        run_insn(8'hCB, 8'h7C, 1'b0, 2, -1, 0, 3, 0, "cb_bit7_hold");
        run_insn(8'hCB, 8'h11, 1'b0, 0, -1, 0, 0, 0, "cb_miss");
    endtask

    task automatic test_stall_call();
        run_insn(8'hCD, 8'h00, 1'b0, 0, 54, 3, 0, 0, "call_stall");
    endtask

    task automatic test_watchdog();
        run_insn(8'h01, 8'h00, 1'b0, 0, -1, 0, 0, 0, "watchdog");
        run_insn(8'h0C, 8'h00, 1'b0, 0, -1, 0, 0, 0, "after_watchdog");
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 256; i++) begin
            r = int'($urandom % 10);
            rom[i]   = mk(r < 5 ? 0 : r < 6 ? 1 : int'($urandom_range(2, 7)),
                          int'($urandom % 16), int'($urandom % 32));
            lut[i]   = 8'($urandom);
            cblut[i] = ($urandom % 8 == 0) ? 8'd0 : 8'($urandom);
        end
        for (int n = 0; n < 40; n++)
            run_insn(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                     -1, 0, 0, 1, "random");
    endtask

    task automatic test_reset_mid();
        init_directed();
        @(negedge clk);
        iMemData = 8'hC9; iMemReady = 1; iStall = 0;
        @(negedge clk);
        iMemData = 8'h00; iMemReady = 0;
        #1;
        vectors++;
        if (oRomAddr !== 8'd85 || oExecValid !== 1'b1) begin
            miscompares++;
            $display("FAIL ret_start addr=%0d exec=%b need 85/1", oRomAddr, oExecValid);
        end
        #2 iReset = 1;
        #1;
        vectors++;
        if ({oExecValid, oPcInc, oFlagUpdate, oEof, oError} !== 5'b0 || oRomAddr !== 8'd0 ||
            oInsnCnt !== 16'd0 || oLutMop !== 8'd0 || {oExecOp, oExecOperand} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_mid strobes=%b err=%b addr=%0d cnt=%0d lutmop=%h need zeros",
                     {oExecValid, oPcInc, oFlagUpdate, oEof}, oError, oRomAddr, oInsnCnt, oLutMop);
        end
        @(negedge clk);
        iReset = 0; iMemData = 8'h55; iMemReady = 1;
        #1;
        vectors++;
        if (oLutMop !== 8'd0 || oExecValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_idle lutmop=%h exec=%b need 00/0", oLutMop, oExecValid);
        end
        exp_insn = '0; exp_err = 0;
        run_insn(8'hC9, 8'h00, 1'b0, 0, -1, 0, 0, 0, "ret_after_reset");
    endtask

    initial begin
        init_directed();
        test_reset();
        test_incr_c();
        test_jrnz();
        test_cb_bit7();
        test_stall_call();
        test_reset();
        test_watchdog();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
